// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/EXT data-memory arbiter with starvation guard; DMEM_ARB_STALL_CNT_EN adds stall_cnt
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
`ifdef DMEM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_EXT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic [AW-1:0] a_q;
  logic [DW-1:0] wd_q, cpu_rd_q, ext_rd_q;
  logic          we_q, done, cpu_done, ext_win;
  assign done      = (state != IDLE) && (cnt == CW'(MEM_LAT - 1));
  assign cpu_done  = (state == GNT_CPU) && done;
  assign ext_ack   = (state == GNT_EXT) && done;
  assign ext_win   = ext_req && (!cpu_req || starve == SW'(STARVE_MAX));
  assign mem_A     = a_q;
  assign mem_WD    = wd_q;
  assign mem_WE    = (state != IDLE) && we_q && (cnt == '0);
  assign cpu_stall = cpu_req && !cpu_done;
  assign cpu_rdata = cpu_done ? mem_RD : cpu_rd_q;
  assign ext_rdata = ext_ack ? mem_RD : ext_rd_q;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      cpu_rd_q <= '0;
      ext_rd_q <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (ext_win) begin
        state  <= GNT_EXT;
        a_q    <= ext_addr;
        wd_q   <= ext_wdata;
        we_q   <= ext_we;
        starve <= '0;
      end else if (cpu_req) begin
        state  <= GNT_CPU;
        a_q    <= cpu_addr;
        wd_q   <= cpu_wdata;
        we_q   <= cpu_we;
        starve <= (ext_req && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (done) begin
        state    <= IDLE;
        cpu_rd_q <= cpu_done ? mem_RD : cpu_rd_q;
        ext_rd_q <= ext_ack ? mem_RD : ext_rd_q;
      end
    end
  end
`ifdef DMEM_ARB_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST) stall_cnt <= '0;
    else if (cpu_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against MEM_LAT=1 and MEM_LAT=3 instances
module tb_dmem_arbiter;
  logic        CLK = 1'b0, RST = 1'b0, ld = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
  logic [31:0] cpu_rdata1, ext_rdata1, mem_a1, mem_wd1, mem_rd1;
  logic [31:0] cpu_rdata3, ext_rdata3, mem_a3, mem_wd3, mem_rd3;
  logic        cpu_stall1, ext_ack1, mem_we1, cpu_stall3, ext_ack3, mem_we3;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  int          nvec = 0, nerr = 0;
  logic        e;
`ifdef DMEM_ARB_STALL_CNT_EN
  logic [15:0] sc1, sc3, scl;
  logic [31:0] cpu_rdatal, ext_rdatal, mem_al, mem_wdl;
  logic [31:0] zero = '0;
  logic        cpu_stalll, ext_ackl, mem_wel;
`endif
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (mem_we1) mem1[mem_a1[7:0]] <= mem_wd1;
    if (mem_we3) mem3[mem_a3[7:0]] <= mem_wd3;
    else if (ld) mem3[8'h20] <= 32'h12345678;
  end
  assign mem_rd1 = mem1[mem_a1[7:0]];
  assign mem_rd3 = mem3[mem_a3[7:0]];
  dmem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) d1 (
    .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata1), .ext_ack(ext_ack1), .mem_A(mem_a1), .mem_WD(mem_wd1),
    .mem_WE(mem_we1), .mem_RD(mem_rd1)
`ifdef DMEM_ARB_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );
  dmem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) d3 (
    .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata3), .ext_ack(ext_ack3), .mem_A(mem_a3), .mem_WD(mem_wd3),
    .mem_WE(mem_we3), .mem_RD(mem_rd3)
`ifdef DMEM_ARB_STALL_CNT_EN
    , .stall_cnt(sc3)
`endif
  );
`ifdef DMEM_ARB_STALL_CNT_EN
  dmem_arbiter #(.MEM_LAT(1000), .STARVE_MAX(4)) dl (
    .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdatal), .cpu_stall(cpu_stalll),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdatal), .ext_ack(ext_ackl), .mem_A(mem_al), .mem_WD(mem_wdl),
    .mem_WE(mem_wel), .mem_RD(zero), .stall_cnt(scl)
  );
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic smp;
    @(negedge CLK);
  endtask
  initial begin
    ld = 1'b1;
    tick;
    ld = 1'b0;
    tick;
    smp;
    chk("rst_mem_a", mem_a1, 32'h0);
    chk("rst_mem_wd", mem_wd1, 32'h0);
    chk("rst_mem_we", mem_we1, 1'b0);
    chk("rst_ext_ack", ext_ack1, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata1, 32'h0);
    chk("rst_ext_rdata", ext_rdata1, 32'h0);
    chk("rst_stall", cpu_stall1, 1'b0);
    // MEM_LAT=1 CPU write then read-back
    tick;
    RST = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    smp;
    chk("wr_c0_stall", cpu_stall1, 1'b1);
    chk("wr_c0_we", mem_we1, 1'b0);
    tick; smp;
    chk("wr_c1_we", mem_we1, 1'b1);
    chk("wr_c1_addr", mem_a1, 32'h10);
    chk("wr_c1_wd", mem_wd1, 32'hDEADBEEF);
    chk("wr_c1_stall", cpu_stall1, 1'b0);
    tick;
    cpu_we = 1'b0; cpu_wdata = '0;
    smp;
    chk("rd_c0_stall", cpu_stall1, 1'b1);
    chk("rd_c0_we", mem_we1, 1'b0);
    tick; smp;
    chk("rd_c1_data", cpu_rdata1, 32'hDEADBEEF);
    chk("rd_c1_stall", cpu_stall1, 1'b0);
    chk("rd_c1_we", mem_we1, 1'b0);
    tick;
    cpu_req = 1'b0;
    smp;
    chk("rd_hold", cpu_rdata1, 32'hDEADBEEF);
    chk("rd_idle_we", mem_we1, 1'b0);
    repeat (4) tick;
    // MEM_LAT=3 EXT read
    ext_req = 1'b1; ext_addr = 32'h20;
    smp;
    chk("ext_c0_ack", ext_ack3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick; smp;
      chk("ext_ack", ext_ack3, (k == 3) ? 32'd1 : 32'd0);
      chk("ext_we", mem_we3, 1'b0);
      chk("ext_addr", mem_a3, 32'h20);
    end
    chk("ext_rdata", ext_rdata3, 32'h12345678);
    tick;
    ext_req = 1'b0;
    smp;
    chk("ext_c4_ack", ext_ack3, 1'b0);
    chk("ext_hold", ext_rdata3, 32'h12345678);
    repeat (4) tick;
    // starvation: C C C C E C C C C E on MEM_LAT=1
    cpu_req = 1'b1; ext_req = 1'b1; cpu_addr = '0;
    for (int k = 1; k <= 19; k++) begin
      tick; smp;
      if (k % 2 == 1) begin
        e = (k == 9 || k == 19);
        chk("starve_cpu_stall", cpu_stall1, e);
        chk("starve_ext_ack", ext_ack1, e);
      end
    end
    tick;
    cpu_req = 1'b0; ext_req = 1'b0;
    repeat (5) tick;
    // reset in cycle 1 of a MEM_LAT=3 CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
    smp;
    chk("abort_c0_stall", cpu_stall3, 1'b1);
    tick; smp;
    chk("abort_c1_we", mem_we3, 1'b1);
    chk("abort_c1_addr", mem_a3, 32'h30);
    RST = 1'b0;
    tick; smp;
    chk("abort_c2_we", mem_we3, 1'b0);
    chk("abort_c2_addr", mem_a3, 32'h0);
    chk("abort_c2_wd", mem_wd3, 32'h0);
    chk("abort_c2_stall", cpu_stall3, 1'b1);
    chk("abort_c2_rdata", cpu_rdata3, 32'h0);
    tick; smp;
    chk("abort_c3_we", mem_we3, 1'b0);
    chk("abort_c3_stall", cpu_stall3, 1'b1);
    chk("abort_c3_ack", ext_ack3, 1'b0);
    tick;
    RST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
`ifdef DMEM_ARB_STALL_CNT_EN
    smp;
    chk("sc_rst", sc1, 16'h0);
    tick;
    cpu_req = 1'b1;
    repeat (10) tick;
    cpu_req = 1'b0;
    smp;
    chk("sc_lat1", sc1, 16'd5);
    chk("sc_lat3", sc3, 16'd8);
    tick;
    cpu_req = 1'b1;
    repeat (70100) tick;
    cpu_req = 1'b0;
    smp;
    chk("sc_sat", scl, 16'hFFFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
